// File: rtl/data_ram_bank_pkg.sv
// data_ram_bank_pkg
// Shared definitions for the data RAM bank: the clear-sequencer FSM state
// encoding and the byte-lane helpers used to size the byte enables.
package data_ram_bank_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Number of byte lanes in a word of the given width.
    function automatic int lane_cnt(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/data_ram_bank_clear_seq.sv
// ram_clear_seq
// Post-reset clear sequencer. It walks the clear address from 0 to DEPTH-1,
// one word per cycle, then settles in READY.
//   clk      in   clock
//   rst      in   synchronous reset, active low; restarts the clear from word 0
//   busy     out  registered, high while the array is being cleared
//   clr_addr out  word being zeroed this cycle
//   clr_we   out  write enable for the clear write
module ram_clear_seq
    import data_ram_bank_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    output logic [CNT_W-1:0] clr_addr,
    output logic             clr_we
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    ram_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // busy drops on the same edge that writes the last word
                    if (cnt == LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READY:   busy  <= 1'b0;
                default: state <= CLEAR;
            endcase
        end
    end

    assign clr_addr = cnt;
    assign clr_we   = busy;

endmodule

// File: rtl/data_ram_bank.sv
// data_ram_bank
// Byte-enabled data memory with configurable width/depth, combinational or
// registered read, a post-reset clear sequencer and an address range check.
//   clk      in   clock
//   rst      in   synchronous reset, active low
//   str      in   store enable
//   ld       in   load enable
//   sel      in   byte lane enables, bit i covers data bits [8i+7:8i]
//   addr     in   word address (never wrapped; words >= DEPTH are errors)
//   data_in  in   store data
//   data_out out  load data
//   rvalid   out  data_out holds valid load data
//   busy     out  clear in progress; accesses are ignored
//   err      out  one-cycle pulse after an access to a word >= DEPTH
module data_ram_bank
    import data_ram_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_REG = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        str,
    input  logic                        ld,
    input  logic [lane_cnt(DATA_W)-1:0] sel,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        rvalid,
    output logic                        busy,
    output logic                        err
);

    localparam int LANES = lane_cnt(DATA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] word_rd;

    ram_clear_seq #(
        .CNT_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_addr (clr_idx),
        .clr_we   (clr_we)
    );

    // Full-width compare: high address bits must not alias onto low words.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[IDX_W-1:0];
    assign word_rd  = in_range ? mem[idx] : '0;

    // Store path; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (clr_we) begin
                mem[clr_idx] <= '0;
            end else if (str && in_range) begin
                for (int i = 0; i < LANES; i++) begin
                    if (sel[i]) mem[idx][BYTE_W*i +: BYTE_W] <= data_in[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) err <= 1'b0;
        else      err <= !busy && (str || ld) && !in_range;
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [DATA_W-1:0] dout_q;
        logic              rv_q;

        // Captures the pre-write word, so read-during-write returns old data.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_q <= '0;
                rv_q   <= 1'b0;
            end else if (ld && !busy) begin
                dout_q <= word_rd;
                rv_q   <= 1'b1;
            end else begin
                rv_q   <= 1'b0;
            end
        end

        assign data_out = dout_q;
        assign rvalid   = rv_q;
    end else begin : g_rd_comb
        assign data_out = busy ? '0 : word_rd;
        assign rvalid   = ld & ~busy;
    end

endmodule

// File: tb/tb_data_ram_bank.sv
module tb_data_ram_bank;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst, str, ld;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    logic [DW-1:0] dout_c, dout_r;
    logic          rv_c, rv_r, busy_c, busy_r, err_c, err_r;

    always #5 clk = ~clk;

    data_ram_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_REG(0)) u_comb (
        .clk(clk), .rst(rst), .str(str), .ld(ld), .sel(sel), .addr(addr),
        .data_in(din), .data_out(dout_c), .rvalid(rv_c), .busy(busy_c), .err(err_c)
    );

    data_ram_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_REG(1)) u_reg (
        .clk(clk), .rst(rst), .str(str), .ld(ld), .sel(sel), .addr(addr),
        .data_in(din), .data_out(dout_r), .rvalid(rv_r), .busy(busy_r), .err(err_r)
    );

    // Expected outputs during one cycle: combinational port from this cycle's
    // inputs, registered outputs from the previous edge.
    typedef struct {
        logic        c_rv;
        logic [31:0] c_data;
        logic        r_rv;
        logic [31:0] r_data;
        logic        err;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   en    = 1'b0;

    // Reference model state
    logic [31:0] m_mem [DEP];
    bit          m_busy, m_rv, m_err;
    logic [3:0]  m_cnt;
    logic [31:0] m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (en) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = q.pop_front();
                check("comb_rvalid", 32'(rv_c),   32'(e.c_rv));
                check("comb_data",   dout_c,      e.c_data);
                check("reg_rvalid",  32'(rv_r),   32'(e.r_rv));
                check("reg_data",    dout_r,      e.r_data);
                check("comb_err",    32'(err_c),  32'(e.err));
                check("reg_err",     32'(err_r),  32'(e.err));
                check("comb_busy",   32'(busy_c), 32'(e.busy));
                check("reg_busy",    32'(busy_r), 32'(e.busy));
            end
        end
    end

    // Drive one cycle, queue the expectation, advance the model past the edge.
    task automatic step(input bit r, input bit s, input bit l, input logic [3:0] sl,
                        input logic [AW-1:0] a, input logic [31:0] d);
        exp_t        e;
        bit          inr;
        logic [31:0] rd, mask;
        rst = r; str = s; ld = l; sel = sl; addr = a; din = d;
        inr = (int'(a) < DEP);
        rd  = inr ? m_mem[a[3:0]] : 32'h0;
        e.c_rv   = l && !m_busy;
        e.c_data = m_busy ? 32'h0 : rd;
        e.r_rv   = m_rv;
        e.r_data = m_dout;
        e.err    = m_err;
        e.busy   = m_busy;
        q.push_back(e);
        if (!r) begin
            m_busy = 1'b1; m_cnt = 4'd0; m_rv = 1'b0; m_err = 1'b0; m_dout = 32'h0;
        end else if (m_busy) begin
            m_mem[m_cnt] = 32'h0;
            m_rv  = 1'b0;
            m_err = 1'b0;
            if (m_cnt == 4'(DEP - 1)) m_busy = 1'b0;
            else                      m_cnt  = m_cnt + 4'd1;
        end else begin
            m_err = (s || l) && !inr;
            m_rv  = l;
            if (l) m_dout = rd;
            if (s && inr) begin
                mask = {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
                m_mem[a[3:0]] = (m_mem[a[3:0]] & ~mask) | (d & mask);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(input bit allow_rst);
        logic [AW-1:0] a;
        bit            r;
        a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 19));
        r = allow_rst ? ($urandom_range(0, 63) != 0) : 1'b1;
        step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
    endtask

    initial begin
        rst = 1'b0; str = 1'b0; ld = 1'b0; sel = 4'h0; addr = '0; din = '0;
        for (int i = 0; i < DEP; i++) m_mem[i] = 32'h0;
        @(posedge clk);
        #1;
        m_busy = 1'b1; m_cnt = 4'd0; m_rv = 1'b0; m_err = 1'b0; m_dout = 32'h0;
        en = 1'b1;

        // Clear after reset, with loads and stores attempted while busy
        for (int i = 0; i < DEP + 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 4'hF, AW'($urandom_range(0, 15)), $urandom);
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 1'b1, 4'h0, AW'(i), 32'h0);

        // Byte-lane merge
        step(1'b1, 1'b1, 1'b0, 4'hF, 10'd5, 32'hDEADBEEF);
        step(1'b1, 1'b1, 1'b0, 4'h1, 10'd5, 32'h000000AA);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd5, 32'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 10'd5, 32'h12345678);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd5, 32'h0);

        // Read during write, same address
        step(1'b1, 1'b1, 1'b0, 4'hF, 10'd3, 32'h11111111);
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'd3, 32'h22222222);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd3, 32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'd3, 32'h0);

        // Out of range, including addresses whose low bits alias word 0
        step(1'b1, 1'b1, 1'b0, 4'hF, 10'd16,   32'hFFFFFFFF);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd0,    32'h0);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd16,   32'h0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 10'h210,  32'hCAFEF00D);
        step(1'b1, 1'b1, 1'b0, 4'hF, 10'h3FF,  32'h55555555);
        step(1'b1, 1'b0, 1'b1, 4'h0, 10'd0,    32'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0,    32'h0);

        for (int i = 0; i < 300; i++) rand_step(1'b0);

        // Reset while READY with a store pending, then reset again mid-clear
        step(1'b0, 1'b1, 1'b1, 4'hF, 10'd1, 32'hDEADBEEF);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b1, 4'hF, AW'($urandom_range(0, 15)), $urandom);
        step(1'b0, 1'b1, 1'b0, 4'hF, 10'd2, 32'h5A5A5A5A);
        for (int i = 0; i < DEP + 2; i++)
            step(1'b1, 1'b1, 1'b1, 4'hF, AW'($urandom_range(0, 15)), $urandom);
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, 1'b1, 4'h0, AW'(i), 32'h0);

        for (int i = 0; i < 300; i++) rand_step(1'b1);
        for (int i = 0; i < DEP + 2; i++) step(1'b1, 1'b0, 1'b1, 4'h0, AW'(i), 32'h0);

        en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_bank.md
Name: data_ram_bank

Overview:
Parametrised byte-enabled data memory for the CPU datapath. Generalises the fixed 32-bit word store in four respects:
- configurable word width and depth;
- selectable combinational or registered read port with a read-valid flag;
- hardware clear sequencer that zeroes the whole array after reset and reports busy;
- address range checking with an error flag.

It sits between the ALU address output and the writeback mux.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 10, word-address width.
DEPTH, 1024, number of words implemented; 1 <= DEPTH <= 2**ADDR_W.
RD_REG, 0, read mode: 0 = combinational read, 1 = registered read (1-cycle latency).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 resets on the clock edge)
str  in  1  store enable
ld  in  1  load enable
sel  in  DATA_W/8  byte lane enables; bit i covers data bits [8i+7:8i]
addr  in  ADDR_W  word address
data_in  in  DATA_W  store data
data_out  out  DATA_W  load data
rvalid  out  1  data_out is valid for a load
busy  out  1  clear sequencer active; all accesses are ignored
err  out  1  one-cycle pulse when an access addresses a word >= DEPTH

Behaviour:
- FSM states: CLEAR, READY.
- Reset (rst=0 at an edge):
  - state <= CLEAR, clear counter <= 0.
  - busy=1, rvalid=0, err=0, data_out register=0.
- CLEAR state:
  - Each cycle writes 0 to word[cnt], then cnt <= cnt+1.
  - When cnt==DEPTH-1 is written, next state is READY and busy drops on that edge. Clearing takes exactly DEPTH cycles.
  - str/ld are ignored: no write, rvalid=0, err=0.
- READY state, store:
  - str=1 and addr<DEPTH: for each i with sel[i]=1, write byte lane i of word[addr]; lanes with sel[i]=0 are unchanged.
  - sel=0 with str=1 is a legal no-op.
- Out-of-range access:
  - (str|ld)=1 and addr>=DEPTH: no write, err=1 for exactly the next cycle (registered).
  - Loads return 0 with rvalid still asserted per the mode rules.
- RD_REG=0:
  - data_out = word[addr] combinationally, whenever READY and addr<DEPTH; otherwise 0.
  - rvalid = ld & ~busy, combinationally.
- RD_REG=1:
  - On an edge with ld=1 in READY, the data_out register captures word[addr] (pre-write value) and rvalid=1 in the following cycle.
  - Otherwise rvalid=0 and data_out holds its last value.
- Read-during-write, same address:
  - RD_REG=1 returns the old word.
  - RD_REG=0 shows the old word until the edge, then the new one.
- Reset mid-operation: a pending store in the same cycle as rst=0 is discarded; the clear restarts from word 0 even if a clear was in progress.
- Address is not wrapped: the high addr bits are compared against DEPTH, never truncated.

Decomposition:
- Shared package: FSM state encoding (CLEAR/READY) and the helper constant for lane count DATA_W/8.
- Natural sub-module: ram_clear_seq (counter + FSM producing busy, clear address and clear write enable). The storage array and port logic stay in data_ram_bank.

Test Plan:
1. rst=0 for 1 cycle, DEPTH=16 -> busy=1 for exactly 16 cycles, then 0; every word reads 0; ld during busy gives rvalid=0.
2. RD_REG=0, store 0xDEADBEEF sel=1111 at addr 5, then store 0x000000AA sel=0001 at addr 5 -> load addr 5 returns 0xDEADBEAA immediately, rvalid=1.
3. RD_REG=1, same cycle str=1 ld=1 addr 3 (old 0x11111111, new 0x22222222) -> next cycle data_out=0x11111111, rvalid=1; a load the following cycle gives 0x22222222.
4. DEPTH=16, ADDR_W=10, str=1 addr 16 data 0xFFFFFFFF -> err=1 for one cycle, word 0 unchanged (no aliasing), load addr 16 returns 0.
5. Reset asserted on cycle 7 of an in-progress clear with str=1 -> store dropped, busy remains 1 for a further full DEPTH cycles.
6. DATA_W=64 build, sel=0x0F store 0x0123456789ABCDEF onto 0 -> word reads 0x0000000089ABCDEF.
